// File: rtl/decimal_key_entry_pkg.sv
// -----------------------------------------------------------------------------
// decimal_key_entry_pkg
// Shared definitions for the PS/2 decimal key entry block:
//   - PS/2 set-2 scan-code constants (digit make codes, break/extend prefixes,
//     Enter, Backspace, Escape)
//   - FSM state enumeration
//   - scan_to_digit(): scan byte -> {is_digit, nibble}
//   - pow10(): elaboration-time helper for the result-width check
// -----------------------------------------------------------------------------
package decimal_key_entry_pkg;

    localparam logic [7:0] SC_0     = 8'h45;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_7     = 8'h3D;
    localparam logic [7:0] SC_8     = 8'h3E;
    localparam logic [7:0] SC_9     = 8'h46;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_BREAK   = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] nibble;
    } digit_t;

    function automatic digit_t scan_to_digit(input logic [7:0] code);
        digit_t d;
        d.is_digit = 1'b1;
        d.nibble   = 4'd0;
        case (code)
            SC_0:    d.nibble = 4'd0;
            SC_1:    d.nibble = 4'd1;
            SC_2:    d.nibble = 4'd2;
            SC_3:    d.nibble = 4'd3;
            SC_4:    d.nibble = 4'd4;
            SC_5:    d.nibble = 4'd5;
            SC_6:    d.nibble = 4'd6;
            SC_7:    d.nibble = 4'd7;
            SC_8:    d.nibble = 4'd8;
            SC_9:    d.nibble = 4'd9;
            default: d.is_digit = 1'b0;
        endcase
        return d;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/decimal_key_entry_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential BCD-to-binary converter: acc = acc*10 + nibble, one nibble per
// cycle, most-significant nibble first.
//   start     : clears the accumulator (one cycle before the first nibble)
//   nib_valid : nibble is valid this cycle
//   nib_last  : this is the final nibble of the stream
//   nibble    : BCD digit
//   result    : converted value, held until the next completed stream
//   done      : one-cycle pulse in the cycle result updates
// -----------------------------------------------------------------------------
module bcd_to_bin_seq
    import decimal_key_entry_pkg::*;
#(
    parameter int VAL_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             nib_valid,
    input  logic             nib_last,
    input  logic [3:0]       nibble,
    output logic [VAL_W-1:0] result,
    output logic             done
);

    logic [VAL_W-1:0] acc;
    logic [VAL_W-1:0] acc_next;

    assign acc_next = acc * VAL_W'(10) + VAL_W'(nibble);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= nib_valid & nib_last;
            if (start)          acc <= '0;
            else if (nib_valid) acc <= acc_next;
            // Result is taken from the combinational next value so the commit
            // lands in the same edge as the final nibble.
            if (nib_valid && nib_last) result <= acc_next;
        end
    end

endmodule

// File: rtl/decimal_key_entry.sv
// -----------------------------------------------------------------------------
// decimal_key_entry
// PS/2 set-2 decimal keypad entry: collects up to N_DIGITS decimal digits in a
// BCD shift register, supports Backspace/Escape, and on Enter converts the
// digits to binary over N_DIGITS cycles.
//   clk, reset_n : clock, asynchronous active-low reset
//   key_code     : scan byte, sampled when key_valid=1 and key_ready=1
//   key_valid    : one-cycle strobe per byte
//   key_ready    : low while a conversion is in progress
//   value        : last committed binary value
//   value_valid  : one-cycle pulse when value updates
//   digit_count  : digits currently entered
//   overflow     : sticky, a digit arrived with the register full
// -----------------------------------------------------------------------------
module decimal_key_entry
    import decimal_key_entry_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int VAL_W    = 10
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    key_code,
    input  logic                          key_valid,
    output logic                          key_ready,
    output logic [VAL_W-1:0]              value,
    output logic                          value_valid,
    output logic [$clog2(N_DIGITS+1)-1:0] digit_count,
    output logic                          overflow
);

    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int DW = 4 * N_DIGITS;
    localparam longint unsigned MAX_DEC = pow10(N_DIGITS);

    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
        $error("decimal_key_entry: N_DIGITS must be in 1..8");
    end
    if ((VAL_W < 40) && ((longint'(1) << VAL_W) < MAX_DEC)) begin : g_bad_val_w
        $error("decimal_key_entry: VAL_W too narrow for N_DIGITS decimal digits");
    end

    state_t        state;
    logic [DW-1:0] digits;
    logic [CW-1:0] conv_cnt;
    digit_t        key_dec;
    logic          accept;
    logic          enter_ok;
    logic          nib_valid;
    logic          nib_last;

    assign key_dec   = scan_to_digit(key_code);
    assign key_ready = (state != ST_CONVERT);
    assign accept    = key_valid & key_ready;
    assign enter_ok  = accept && (state == ST_ENTRY) &&
                       (key_code == SC_ENTER) && (digit_count != '0);
    assign nib_valid = (state == ST_CONVERT);
    assign nib_last  = (conv_cnt == CW'(N_DIGITS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_ENTRY;
            digits      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
            conv_cnt    <= '0;
        end else begin
            case (state)
                ST_ENTRY: begin
                    if (accept) begin
                        if (key_dec.is_digit) begin
                            if (digit_count == CW'(N_DIGITS)) begin
                                overflow <= 1'b1;
                            end else begin
                                digits      <= (digits << 4) | DW'(key_dec.nibble);
                                digit_count <= digit_count + CW'(1);
                            end
                        end else begin
                            case (key_code)
                                SC_BREAK: state <= ST_BREAK;
                                SC_BKSP: begin
                                    if (digit_count != '0) begin
                                        digits      <= digits >> 4;
                                        digit_count <= digit_count - CW'(1);
                                    end
                                end
                                SC_ESC: begin
                                    digits      <= '0;
                                    digit_count <= '0;
                                    overflow    <= 1'b0;
                                end
                                SC_ENTER: begin
                                    if (enter_ok) begin
                                        state    <= ST_CONVERT;
                                        conv_cnt <= '0;
                                    end
                                end
                                // E0 and unknown codes are dropped here.
                                default: ;
                            endcase
                        end
                    end
                end
                ST_BREAK: begin
                    if (accept) state <= ST_ENTRY;
                end
                ST_CONVERT: begin
                    // The top nibble feeds the converter; shifting up presents
                    // the next-lower digit on the following cycle.
                    digits   <= digits << 4;
                    conv_cnt <= conv_cnt + CW'(1);
                    if (nib_last) begin
                        state       <= ST_ENTRY;
                        digits      <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                    end
                end
                default: state <= ST_ENTRY;
            endcase
        end
    end

    bcd_to_bin_seq #(
        .VAL_W (VAL_W)
    ) u_conv (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (enter_ok),
        .nib_valid (nib_valid),
        .nib_last  (nib_last),
        .nibble    (digits[DW-1 -: 4]),
        .result    (value),
        .done      (value_valid)
    );

endmodule

// File: tb/tb_decimal_key_entry.sv
// -----------------------------------------------------------------------------
// tb_decimal_key_entry
// Self-checking bench for decimal_key_entry (N_DIGITS=3, VAL_W=10). Directed
// scenarios followed by random key traffic, all compared against a queue-based
// model of the keypad entry behaviour.
// -----------------------------------------------------------------------------
module tb_decimal_key_entry;

    localparam int N     = 3;
    localparam int VAL_W = 10;

    logic             clk;
    logic             reset_n;
    logic [7:0]       key_code;
    logic             key_valid;
    logic             key_ready;
    logic [VAL_W-1:0] value;
    logic             value_valid;
    logic [1:0]       digit_count;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: entered digits oldest-first.
    int unsigned m_dig[$];
    bit          m_ovf;
    bit          m_brk;
    int unsigned m_value;

    decimal_key_entry #(
        .N_DIGITS (N),
        .VAL_W    (VAL_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .value       (value),
        .value_valid (value_valid),
        .digit_count (digit_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int code_digit(input logic [7:0] c);
        case (c)
            8'h45: return 0;
            8'h16: return 1;
            8'h1E: return 2;
            8'h26: return 3;
            8'h25: return 4;
            8'h2E: return 5;
            8'h36: return 6;
            8'h3D: return 7;
            8'h3E: return 8;
            8'h46: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic int unsigned digits_value();
        int unsigned v;
        int unsigned p;
        v = 0;
        p = 1;
        for (int i = m_dig.size() - 1; i >= 0; i--) begin
            v += m_dig[i] * p;
            p *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_dig.delete();
        m_ovf   = 1'b0;
        m_brk   = 1'b0;
        m_value = 0;
    endtask

    // Applies one accepted byte; reports whether a conversion starts.
    task automatic model_apply(input logic [7:0] c, output bit conv, output int unsigned expv);
        int d;
        conv = 1'b0;
        expv = 0;
        d    = code_digit(c);
        if (m_brk) begin
            m_brk = 1'b0;
        end else if (d >= 0) begin
            if (m_dig.size() == N) m_ovf = 1'b1;
            else                   m_dig.push_back(d);
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else if (c == 8'h66) begin
            if (m_dig.size() > 0) void'(m_dig.pop_back());
        end else if (c == 8'h76) begin
            m_dig.delete();
            m_ovf = 1'b0;
        end else if (c == 8'h5A) begin
            if (m_dig.size() > 0) begin
                conv = 1'b1;
                expv = digits_value();
            end
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, ".count"},    32'(digit_count), m_dig.size());
        check({tag, ".overflow"}, 32'(overflow),    32'(m_ovf));
        check({tag, ".ready"},    32'(key_ready),   1);
        check({tag, ".vvalid"},   32'(value_valid), 0);
        check({tag, ".value"},    32'(value),       m_value);
    endtask

    // Entered at the negedge of the first cycle after the Enter strobe.
    task automatic run_convert(input int unsigned expv, input bit inject, input logic [7:0] inj_code);
        for (int i = 1; i <= N; i++) begin
            check("conv.vvalid_early", 32'(value_valid), 0);
            check("conv.ready_low",    32'(key_ready),   0);
            if (i == 1 && inject) begin
                key_code  = inj_code;
                key_valid = 1'b1;
            end
            @(negedge clk);
            key_valid = 1'b0;
        end
        m_value = expv;
        m_dig.delete();
        m_ovf = 1'b0;
        check("commit.vvalid",   32'(value_valid), 1);
        check("commit.value",    32'(value),       m_value);
        check("commit.count",    32'(digit_count), 0);
        check("commit.overflow", 32'(overflow),    0);
        check("commit.ready",    32'(key_ready),   1);
        @(negedge clk);
        check("commit.vvalid_once", 32'(value_valid), 0);
        check("commit.value_hold",  32'(value),       m_value);
    endtask

    task automatic send(input logic [7:0] c, input bit inject, input logic [7:0] inj_code);
        bit          conv;
        int unsigned expv;
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        model_apply(c, conv, expv);
        if (conv) run_convert(expv, inject, inj_code);
        else      check_idle_state($sformatf("key_%02h", c));
    endtask

    task automatic send_list(input logic [7:0] codes[$]);
        foreach (codes[i]) send(codes[i], 1'b0, 8'h00);
    endtask

    task automatic idle_no_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle.vvalid", 32'(value_valid), 0);
            check("idle.value",  32'(value),       m_value);
        end
    endtask

    initial begin
        logic [7:0] pool[$];
        logic [7:0] c;
        int         r;

        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = 8'h00;
        model_reset();
        #3;
        check_idle_state("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle_no_pulse(2);

        // 123 with break codes interleaved; pulse 4 cycles after Enter.
        send_list('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26, 8'h5A});
        check("dir123.value", 32'(value), 123);
        send_list('{8'hF0, 8'h5A});
        idle_no_pulse(N + 2);

        // Overflow on fourth digit, cleared by commit.
        send_list('{8'h46, 8'h46, 8'h46, 8'h3E});
        check("ovf.flag",  32'(overflow),    1);
        check("ovf.count", 32'(digit_count), 3);
        send(8'h5A, 1'b0, 8'h00);
        check("dir999.value", 32'(value), 999);

        // Backspace: 4,5,<bs>,6 -> 46; lone Enter afterwards does nothing.
        send_list('{8'h25, 8'hF0, 8'h25, 8'h2E, 8'hF0, 8'h2E, 8'h66, 8'hF0, 8'h66,
                    8'h36, 8'hF0, 8'h36, 8'h5A, 8'hF0, 8'h5A});
        check("dir46.value", 32'(value), 46);
        send(8'h5A, 1'b0, 8'h00);
        idle_no_pulse(N + 2);

        // Escape clears entry; Enter then ignored.
        send_list('{8'h3D, 8'h76, 8'h5A});
        check("esc.count", 32'(digit_count), 0);
        idle_no_pulse(N + 2);
        check("esc.value", 32'(value), 46);

        // Reset two cycles after Enter aborts conversion.
        send(8'h26, 1'b0, 8'h00);
        key_code  = 8'h5A;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_idle_state("midreset");
        @(negedge clk);
        check_idle_state("midreset_hold");
        reset_n = 1'b1;
        idle_no_pulse(N + 2);
        send_list('{8'h16, 8'hE0, 8'h5A});
        check("ext_enter.value", 32'(value), 1);

        // Byte strobed during CONVERT is dropped.
        send_list('{8'h1E, 8'h45});
        send(8'h5A, 1'b1, 8'h16);
        check("drop.value", 32'(value), 20);

        // Random traffic.
        pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if      (r < 50) c = pool[$urandom_range(0, 9)];
            else if (r < 58) c = 8'hF0;
            else if (r < 62) c = 8'hE0;
            else if (r < 70) c = 8'h66;
            else if (r < 74) c = 8'h76;
            else if (r < 88) c = 8'h5A;
            else             c = 8'($urandom_range(0, 255));
            send(c, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) idle_no_pulse($urandom_range(1, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decimal_key_entry.md
DECIMAL_KEY_ENTRY -- requirements
Module: decimal_key_entry

Interface
REQ-001 Parameter N_DIGITS, default 3: maximum number of decimal digits held (range 1..8).
REQ-002 Parameter VAL_W, default 10: width of the binary result; elaboration SHALL fail if 2^VAL_W < 10^N_DIGITS.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 key_code  input  8  PS/2 set-2 scan byte; sampled only when key_valid=1.
REQ-006 key_valid  input  1  one-cycle strobe per received byte.
REQ-007 key_ready  output  1  high when a byte will be accepted; low during CONVERT.
REQ-008 value  output  VAL_W  last committed binary value; holds until the next commit.
REQ-009 value_valid  output  1  one-cycle pulse when value updates.
REQ-010 digit_count  output  $clog2(N_DIGITS+1)  number of digits currently entered.
REQ-011 overflow  output  1  sticky; set when a digit arrives with digit_count=N_DIGITS.

Function
REQ-012 Digit make codes SHALL map as: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
REQ-013 Digits SHALL be stored as a BCD shift register of N_DIGITS nibbles: new digit enters the least-significant nibble; older digits shift up; digit_count increments.
REQ-014 Digit with digit_count=N_DIGITS: the digit is discarded, the register is unchanged, overflow is set.
REQ-015 Backspace (66) SHALL shift the register down one nibble, zero-filling the top nibble, and decrement digit_count; no effect at digit_count=0.
REQ-016 Escape (76) SHALL clear all nibbles, digit_count and overflow.
REQ-017 Enter (5A) with digit_count>0 SHALL enter CONVERT; with digit_count=0 it SHALL be ignored (no pulse).
REQ-018 F0 SHALL move ENTRY to BREAK; the next accepted byte is discarded, then ENTRY resumes.
REQ-019 E0 SHALL be discarded without a state change, so E0 5A acts as Enter.
REQ-020 All other codes SHALL be ignored.
REQ-021 States: ENTRY, BREAK, CONVERT.
- ENTRY->BREAK on F0.
- BREAK->ENTRY on any accepted byte.
- ENTRY->CONVERT on a valid Enter.
- CONVERT->ENTRY after N_DIGITS cycles.
REQ-022 CONVERT SHALL evaluate acc = acc*10 + nibble, most-significant nibble first, one nibble per cycle, starting from acc=0.
REQ-023 value SHALL load acc and value_valid SHALL pulse exactly N_DIGITS+1 cycles after the Enter strobe cycle.
- In the same cycle, digits, digit_count and overflow SHALL clear.
REQ-024 key_ready=0 throughout CONVERT; a key_valid strobe while key_ready=0 SHALL be dropped with no effect.
REQ-025 All arithmetic SHALL be unsigned at VAL_W bits; REQ-002 guarantees no truncation.

Reset
REQ-026 On reset_n=0, immediately and regardless of state: state=ENTRY, all nibbles=0, digit_count=0, overflow=0, value=0, value_valid=0, key_ready=1.
REQ-027 Reset asserted mid-CONVERT SHALL abort the conversion with no value_valid pulse.
- Operation resumes on the first clock edge after reset_n deasserts.

Structure
REQ-028 A shared package SHALL hold:
- scan-code constants (digits, F0, E0, 5A, 66, 76);
- the state enumeration;
- the scan-code-to-digit function returning {is_digit, nibble}.
REQ-029 One sub-module, bcd_to_bin_seq, SHALL implement the CONVERT datapath (start, nibble stream in; result plus done out); the key decoder stays in the top module.

Verification
REQ-030 N_DIGITS=3: keys 16,F0,16,1E,F0,1E,26,F0,26,5A,F0,5A -> value=123, value_valid pulses once, 4 cycles after the 5A strobe.
REQ-031 Keys 46,46,46,3E -> overflow=1, digit_count=3; then 5A -> value=999; overflow=0 after the commit.
REQ-032 Keys 25,2E,66,36,5A (break codes included) -> value=46; then 5A alone -> no value_valid pulse.
REQ-033 Keys 3D,76,5A -> no pulse, digit_count=0, value unchanged.
REQ-034 Key 26 then 5A; assert reset_n=0 two cycles after Enter -> no pulse, value=0; then keys 16,E0,5A -> value=1.
REQ-035 Strobe 16 during CONVERT -> byte dropped, key_ready=0, committed value unaffected.
